// File: rtl/pwm_multi_if.sv
// Bus bundle for pwm_multi: run enable, shadow-register writes and PWM outputs.
// The master side drives configuration; the slave side is the PWM block.
interface pwm_multi_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
);
   logic                      en;
   logic [WIDTH-1:0]          period;
   logic                      period_valid;
   logic                      center;
   logic [CHANNELS*WIDTH-1:0] duty;
   logic [CHANNELS-1:0]       duty_valid;
   logic [CHANNELS-1:0]       out;
   logic                      ready;

   modport master (
      output en, period, period_valid, center, duty, duty_valid,
      input  out, ready
   );

   modport slave (
      input  en, period, period_valid, center, duty, duty_valid,
      output out, ready
   );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared edge- or center-aligned counter with shadowed period/mode/duty
// registers that take effect at each period boundary or while idle.
module pwm_multi #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input logic         clk,
   input logic         rst_n,
   pwm_multi_if.slave  bus
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

   logic [WIDTH-1:0]                 cnt_q, cnt_d;
   logic                             dn_q, dn_d;
   logic [WIDTH-1:0]                 pend_p_q, pend_p_d, act_p_q, act_p_d;
   logic                             pend_c_q, pend_c_d, act_c_q, act_c_d;
   logic [CHANNELS-1:0][WIDTH-1:0]   pend_duty_q, pend_duty_d, act_duty_q, act_duty_d;
   logic [CHANNELS-1:0]              out_q, out_d;
   logic [WIDTH-1:0]                 last;
   logic                             ready_c;
   logic                             load;

   assign last = act_p_q - ONE;

   // Boundary: the counter's next value begins a new period.
   always_comb begin
      ready_c = 1'b0;
      if (bus.en) begin
         if (!act_c_q) ready_c = (cnt_q == last);
         else          ready_c = (dn_q && cnt_q == ONE) || (act_p_q <= TWO && cnt_q == last);
      end
   end

   always_comb begin
      pend_p_d = pend_p_q;
      pend_c_d = pend_c_q;
      if (bus.period_valid && bus.period != '0) begin
         pend_p_d = bus.period;
         pend_c_d = bus.center;
      end
      for (int i = 0; i < CHANNELS; i++)
         pend_duty_d[i] = bus.duty_valid[i] ? bus.duty[i*WIDTH +: WIDTH] : pend_duty_q[i];

      // Loading from the _d side lets a same-cycle write go straight to the active set.
      load       = ready_c || !bus.en;
      act_p_d    = load ? pend_p_d    : act_p_q;
      act_c_d    = load ? pend_c_d    : act_c_q;
      act_duty_d = load ? pend_duty_d : act_duty_q;

      cnt_d = '0;
      dn_d  = 1'b0;
      if (bus.en && !ready_c) begin
         if (!act_c_q) begin
            cnt_d = cnt_q + ONE;
         end else if (dn_q || cnt_q == last) begin
            cnt_d = cnt_q - ONE;
            dn_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + ONE;
         end
      end

      for (int i = 0; i < CHANNELS; i++)
         out_d[i] = bus.en && (cnt_q < act_duty_q[i]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         dn_q        <= 1'b0;
         pend_p_q    <= ONE;
         act_p_q     <= ONE;
         pend_c_q    <= 1'b0;
         act_c_q     <= 1'b0;
         pend_duty_q <= '0;
         act_duty_q  <= '0;
         out_q       <= '0;
      end else begin
         cnt_q       <= cnt_d;
         dn_q        <= dn_d;
         pend_p_q    <= pend_p_d;
         act_p_q     <= act_p_d;
         pend_c_q    <= pend_c_d;
         act_c_q     <= act_c_d;
         pend_duty_q <= pend_duty_d;
         act_duty_q  <= act_duty_d;
         out_q       <= out_d;
      end
   end

   assign bus.out   = out_q;
   assign bus.ready = ready_c;
endmodule

// File: tb/tb_pwm_multi.sv
// Testbench for pwm_multi: vector table for edge/center patterns, then hand sequences
// for mid-period writes, simultaneous write+boundary, enable drop and mid-period reset.
module tb_pwm_multi;
   localparam int W  = 8;
   localparam int CH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pwm_multi_if #(.WIDTH(W), .CHANNELS(CH)) bus ();
   pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      string           tag;
      logic [CH-1:0]   out;
      logic            rdy;
   } exp_t;

   typedef struct {
      logic            en;
      logic            pv;
      logic [W-1:0]    per;
      logic            ctr;
      logic [CH-1:0]   dv;
      logic [CH*W-1:0] duty;
      logic [CH-1:0]   eo;
      logic            er;
   } vec_t;

   exp_t sb[$];
   exp_t got_e;
   vec_t tbl[28];
   int   checks = 0;
   int   failures = 0;

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         got_e = sb.pop_front();
         checks++;
         if (bus.out !== got_e.out || bus.ready !== got_e.rdy) begin
            failures++;
            $display("FAIL %s: out=%b ready=%b, expected out=%b ready=%b",
                     got_e.tag, bus.out, bus.ready, got_e.out, got_e.rdy);
         end
      end
   end

   function automatic vec_t mk(logic en, logic pv, logic [W-1:0] per, logic ctr,
                               logic [CH-1:0] dv, logic [CH*W-1:0] duty,
                               logic [CH-1:0] eo, logic er);
      vec_t v;
      v.en = en; v.pv = pv; v.per = per; v.ctr = ctr;
      v.dv = dv; v.duty = duty; v.eo = eo; v.er = er;
      return v;
   endfunction

   task automatic tick(input string tag, input logic [CH-1:0] eo, input logic er);
      exp_t e;
      e.tag = tag; e.out = eo; e.rdy = er;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.period_valid = 1'b0;
      bus.duty_valid   = '0;
   endtask

   task automatic wr_duty(input int ch, input logic [W-1:0] v);
      bus.duty[ch*W +: W] = v;
      bus.duty_valid[ch]  = 1'b1;
   endtask

   task automatic wr_period(input logic [W-1:0] p, input logic c);
      bus.period       = p;
      bus.center       = c;
      bus.period_valid = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Edge P=5, duty {ch3=7,ch2=5,ch1=2,ch0=0}, then center P=4 with only ch1=2.
      tbl[0]  = mk(1, 1, 8'd5, 0, 4'hF, {8'd7, 8'd5, 8'd2, 8'd0}, 4'b0000, 1);
      tbl[1]  = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b0000, 0);
      tbl[2]  = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b1110, 0);
      tbl[3]  = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b1110, 0);
      tbl[4]  = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b1100, 0);
      tbl[5]  = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b1100, 1);
      tbl[6]  = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b1100, 0);
      tbl[7]  = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b1110, 0);
      tbl[8]  = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b1110, 0);
      tbl[9]  = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b1100, 0);
      tbl[10] = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b1100, 1);
      tbl[11] = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b1100, 0);
      tbl[12] = mk(1, 1, 8'd4, 1, 4'hF, {8'd0, 8'd0, 8'd2, 8'd0}, 4'b1110, 0);
      tbl[13] = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b1110, 0);
      tbl[14] = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b1100, 0);
      tbl[15] = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b1100, 1);
      tbl[16] = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b1100, 0);
      tbl[17] = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b0010, 0);
      tbl[18] = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b0010, 0);
      tbl[19] = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b0000, 0);
      tbl[20] = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b0000, 0);
      tbl[21] = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b0000, 1);
      tbl[22] = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b0010, 0);
      tbl[23] = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b0010, 0);
      tbl[24] = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b0010, 0);
      tbl[25] = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b0000, 0);
      tbl[26] = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b0000, 0);
      tbl[27] = mk(1, 0, 8'd0, 0, 4'h0, '0, 4'b0000, 1);

      bus.en = 1'b0; bus.period = '0; bus.period_valid = 1'b0;
      bus.center = 1'b0; bus.duty = '0; bus.duty_valid = '0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;

      // Reset values: idle outputs, and with en=1 the P=1 reset state is a boundary.
      tick("rst_idle", 4'b0000, 0);
      bus.en = 1'b1;
      tick("rst_ready", 4'b0000, 1);
      rst_n = 1'b1;

      for (int i = 0; i < 28; i++) begin
         bus.en = tbl[i].en;
         bus.period_valid = tbl[i].pv;
         bus.period = tbl[i].per;
         bus.center = tbl[i].ctr;
         bus.duty_valid = tbl[i].dv;
         bus.duty = tbl[i].duty;
         tick($sformatf("vec%0d", i), tbl[i].eo, tbl[i].er);
      end

      // Idle load of edge P=8, duty0=3; mid-period duty0 3->1 and a period=0 write.
      bus.en = 1'b0;
      wr_period(8'd8, 1'b0);
      bus.duty = {8'd0, 8'd0, 8'd0, 8'd3};
      bus.duty_valid = 4'hF;
      tick("idle_load", 4'b0010, 0);
      bus.en = 1'b1;
      tick("p8_start", 4'b0000, 0);
      tick("p8_c1", 4'b0001, 0);
      wr_duty(0, 8'd1);
      wr_period(8'd0, 1'b1);
      tick("midwr_c2", 4'b0001, 0);
      tick("midwr_c3", 4'b0001, 0);
      for (int k = 0; k < 3; k++) tick("old_duty_tail", 4'b0000, 0);
      tick("p8_bound", 4'b0000, 1);
      tick("new_duty_c0", 4'b0000, 0);
      tick("new_duty_c1", 4'b0001, 0);
      for (int k = 0; k < 5; k++) tick("new_duty_tail", 4'b0000, 0);
      tick("p0_ignored_bound", 4'b0000, 1);
      tick("p8_c0", 4'b0000, 0);

      // Period 8->4 queued, then 4->6 written in the boundary cycle itself.
      wr_period(8'd4, 1'b0);
      tick("wr4", 4'b0001, 0);
      for (int k = 0; k < 5; k++) tick("p8_last", 4'b0000, 0);
      tick("p8_to_4", 4'b0000, 1);
      tick("p4_c0", 4'b0000, 0);
      tick("p4_c1", 4'b0001, 0);
      tick("p4_c2", 4'b0000, 0);
      wr_period(8'd6, 1'b0);
      tick("wr6_at_ready", 4'b0000, 1);
      tick("p6_c0", 4'b0000, 0);
      tick("p6_c1", 4'b0001, 0);
      for (int k = 0; k < 3; k++) tick("p6_mid", 4'b0000, 0);
      tick("p6_bound", 4'b0000, 1);
      tick("p6_c0b", 4'b0000, 0);
      tick("p6_c1b", 4'b0001, 0);

      // Enable dropped mid-period, then restarted.
      bus.en = 1'b0;
      wr_duty(0, 8'd5);
      tick("en_off_load", 4'b0000, 0);
      bus.en = 1'b1;
      tick("en_c0", 4'b0000, 0);
      tick("en_c1", 4'b0001, 0);
      tick("en_c2", 4'b0001, 0);
      bus.en = 1'b0;
      tick("en_drop", 4'b0001, 0);
      tick("en_low", 4'b0000, 0);
      bus.en = 1'b1;
      tick("restart_c0", 4'b0000, 0);
      for (int k = 0; k < 4; k++) tick("restart_run", 4'b0001, 0);
      tick("restart_bound", 4'b0001, 1);
      tick("restart_c0b", 4'b0000, 0);
      tick("restart_c1b", 4'b0001, 0);

      // Reset at counter=3 with a pending duty write; valid during reset also ignored.
      wr_duty(0, 8'd2);
      tick("pend_wr", 4'b0001, 0);
      rst_n = 1'b0;
      wr_duty(0, 8'd7);
      tick("rst_mid", 4'b0001, 0);
      rst_n = 1'b1;
      tick("rst_after", 4'b0000, 1);
      tick("rst_p1", 4'b0000, 1);
      tick("pend_lost", 4'b0000, 1);

      @(negedge clk);
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: left=%0d expected=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
